// File: rtl/reduce_f32_pkg.sv
// Shared types, constants and helpers for the reduce_f32 streaming sum reducer.
package reduce_f32_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam logic [31:0] F32_POS_ZERO = 32'h0000_0000;

  function automatic logic f32_is_nan(input logic [31:0] word);
    return (word[30:23] == 8'hFF) && (word[22:0] != 23'h00_0000);
  endfunction

endpackage

// File: rtl/reduce_f32_tag_pipe.sv
// Liveness tags travelling alongside the external adder pipeline; ret_v marks a
// live partial arriving on add_res, occ counts live partials still in flight.
module reduce_f32_tag_pipe
  import reduce_f32_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_in,
  output logic             ret_v,
  output logic [OCC_W-1:0] occ
);

  logic [DEPTH-1:0] tags_r;
  logic [OCC_W-1:0] occ_r;

  // Tag shift register and running population count kept in step with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags_r <= {DEPTH{1'b0}};
      occ_r  <= {OCC_W{1'b0}};
    end else begin
      tags_r <= {tags_r[DEPTH-2:0], shift_in};
      occ_r  <= occ_r + OCC_W'(shift_in) - OCC_W'(tags_r[DEPTH-1]);
    end
  end

  assign ret_v = tags_r[DEPTH-1];
  assign occ   = occ_r;

endmodule

// File: rtl/reduce_f32.sv
// Streaming f32 sum reduction controller driving an external fixed-latency adder.
// Optional sticky NaN flag output enabled by defining REDUCE_F32_NAN_FLAG_EN.
module reduce_f32
  import reduce_f32_pkg::*;
#(
  parameter int ADD_LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef REDUCE_F32_NAN_FLAG_EN
  ,
  output logic        nan_seen
`endif
);

  localparam int OCC_W = $clog2(ADD_LATENCY + 1);

  state_e      state_r, state_nxt;
  logic [31:0] add_a_r, add_b_r, a_nxt_s, b_nxt_s;
  logic [31:0] hold_r, hold_nxt_s;
  logic        hold_v_r, hold_v_nxt_s;
  logic        in_ready_r, out_valid_r;
  logic [31:0] out_data_r;
  logic        accept_s, issue_tag_s, done_s, ret_v_s;
  logic [OCC_W-1:0] occ_s;

  reduce_f32_tag_pipe #(
    .DEPTH (ADD_LATENCY),
    .OCC_W (OCC_W)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .shift_in (issue_tag_s),
    .ret_v    (ret_v_s),
    .occ      (occ_s)
  );

  assign accept_s = in_valid && in_ready_r;

  // Next-state, adder operand selection and pairwise collapse of partials.
  always_comb begin
    state_nxt    = state_r;
    a_nxt_s      = F32_POS_ZERO;
    b_nxt_s      = F32_POS_ZERO;
    issue_tag_s  = 1'b0;
    hold_nxt_s   = hold_r;
    hold_v_nxt_s = hold_v_r;
    done_s       = 1'b0;
    case (state_r)
      ACCUM: begin
        a_nxt_s     = accept_s ? in_data : F32_POS_ZERO;
        b_nxt_s     = ret_v_s ? add_res : F32_POS_ZERO;
        issue_tag_s = accept_s | ret_v_s;
        if (accept_s && in_last) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt = ACCUM;
        end
      end
      DRAIN: begin
        if (ret_v_s && hold_v_r) begin
          a_nxt_s      = hold_r;
          b_nxt_s      = add_res;
          issue_tag_s  = 1'b1;
          hold_v_nxt_s = 1'b0;
        end else if (ret_v_s) begin
          hold_nxt_s   = add_res;
          hold_v_nxt_s = 1'b1;
        end else if (hold_v_r && (occ_s == {OCC_W{1'b0}})) begin
          // Last surviving partial with nothing left in flight is the total.
          done_s       = 1'b1;
          hold_v_nxt_s = 1'b0;
          state_nxt    = OUT;
        end else begin
          state_nxt = DRAIN;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = ACCUM;
        end else begin
          state_nxt = OUT;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  // State, operand, hold and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ACCUM;
      add_a_r     <= F32_POS_ZERO;
      add_b_r     <= F32_POS_ZERO;
      hold_r      <= F32_POS_ZERO;
      hold_v_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= F32_POS_ZERO;
    end else begin
      state_r     <= state_nxt;
      add_a_r     <= a_nxt_s;
      add_b_r     <= b_nxt_s;
      hold_r      <= hold_nxt_s;
      hold_v_r    <= hold_v_nxt_s;
      in_ready_r  <= (state_nxt == ACCUM);
      out_valid_r <= (state_nxt == OUT);
      out_data_r  <= done_s ? hold_r : out_data_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign add_a     = add_a_r;
  assign add_b     = add_b_r;

`ifdef REDUCE_F32_NAN_FLAG_EN
  logic nan_seen_r;

  // Sticky NaN indication for the reduction currently being formed or presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_seen_r <= 1'b0;
    end else if ((state_r == OUT) && out_ready) begin
      nan_seen_r <= 1'b0;
    end else if (accept_s && f32_is_nan(in_data)) begin
      nan_seen_r <= 1'b1;
    end else begin
      nan_seen_r <= nan_seen_r;
    end
  end

  assign nan_seen = nan_seen_r;
`endif

endmodule

// File: doc/reduce_f32.md
# reduce_f32

Streaming single-precision sum reduction controller that sits directly upstream of the pipelined `add_f32` adder. It feeds the adder's `a`/`b` operands and consumes its result stream. It accepts a valid/ready stream of f32 words terminated by a `last` marker. While the stream runs, it keeps up to `ADD_LATENCY` partial sums circulating through the adder. After `last`, it collapses those partials pairwise and presents one f32 total on a valid/ready output. The adder core has fixed latency, has no stall, and is instantiated outside this block.

## Interface
- `ADD_LATENCY`, default 8: adder latency in cycles, from operands driven to `add_res` valid; must be ≥ 2.
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input word valid.
- `in_ready`, out, 1: block accepts the input word this cycle.
- `in_data`, in, 32: f32 operand.
- `in_last`, in, 1: final word of the current reduction; qualified by `in_valid && in_ready`.
- `add_a`, out, 32: adder operand a (registered).
- `add_b`, out, 32: adder operand b (registered).
- `add_res`, in, 32: adder result. It corresponds to the operands driven exactly `ADD_LATENCY` cycles earlier.
- `out_valid`, out, 1: total available.
- `out_ready`, in, 1: consumer accepts the total.
- `out_data`, out, 32: f32 total.
- `nan_seen`, out, 1: present only with the configuration macro.

## Operation
- States: ACCUM, DRAIN, OUT. Reset state is ACCUM.
- Tag pipe: a 1-bit shift register of depth `ADD_LATENCY` marks which adder slots carry a live partial.
  - `ret_v` = tag at the output end of the pipe.
  - `occ` = number of set tags.
- **ACCUM**
  - `in_ready`=1.
  - Every cycle, `add_a` ← `in_data` if accepted, else +0.0 (32'h0).
  - `add_b` ← `add_res` if `ret_v`, else +0.0.
  - Issued tag = accepted | `ret_v`.
  - An accepted word with `in_last` moves the state to DRAIN; that word is issued normally.
- **DRAIN**
  - `in_ready`=0.
  - Hold register `hold`/`hold_v`.
  - If `ret_v` and `hold_v`: issue `hold`+`add_res`, tag 1, `hold_v`←0.
  - If `ret_v` and !`hold_v`: `hold`←`add_res`, `hold_v`←1, issue +0.0+(+0.0) with tag 0.
  - If !`ret_v`, `hold_v`, and `occ`==0: `out_data`←`hold`, go to OUT, clear `hold_v`.
- **OUT**
  - `out_valid`=1 and `in_ready`=0.
  - `out_data` holds stable until `out_ready`.
  - On handshake: go to ACCUM. `out_valid`=0 on the following cycle.
- Arithmetic rules:
  - Padding is +0.0, so a sum of only −0.0 inputs yields +0.0.
  - Summation order is unspecified. Results may differ from sequential summation by normal rounding.
- A one-word reduction is legal; the result equals the word.
- Boundary conditions:
  - A tag issued in the cycle of `last` is still counted in `occ` during DRAIN.
  - `ret_v` and done are never both true in the same cycle, because done requires !`ret_v`.
- Reset, including mid-DRAIN or mid-OUT:
  - All tags, `hold_v` and state clear.
  - Stale adder contents return with tag 0 and are ignored.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `add_a`=0, `add_b`=0, `nan_seen`=0.
- Throughput: one input word per cycle in ACCUM, with no bubbles required.
- Latency from the `last` handshake to `out_valid` is at most `ADD_LATENCY`·(⌈log2 `ADD_LATENCY`⌉+1)+2 cycles.
- The next reduction's first word is accepted no earlier than the cycle after the output handshake.
- `add_a`/`add_b` and the tag pipe update on the same edge. `add_res` is sampled combinationally and aligned with the tag-pipe output.

## Configuration
- Macro: `REDUCE_F32_NAN_FLAG_EN`.
- With the macro defined:
  - Port `nan_seen` exists.
  - It is a sticky flag, set when any accepted `in_data` has exponent 8'hFF and mantissa ≠ 0.
  - It is valid with `out_valid` and cleared on the output handshake or reset.
- Without the macro: the port and its logic are absent. Data behaviour is identical.

## Structure
- Package `reduce_f32_pkg` holds:
  - the state enum (ACCUM/DRAIN/OUT);
  - `F32_POS_ZERO` = 32'h0000_0000;
  - the `f32_is_nan` function.
- Sub-module `reduce_f32_tag_pipe`:
  - parameterised depth;
  - shift-in bit, `ret_v` out, `occ` count out;
  - asynchronous clear.

## Test plan
Bench models the adder as an `ADD_LATENCY`-deep behavioural f32 add.
- L=4, back-to-back 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000), last on 4.0 -> `out_data`=0x41200000 (10.0).
- Single word 0x40A00000 with `in_last` -> `out_data`=0x40A00000; `in_ready` low until the handshake.
- Eight words of 1.0 with `in_valid` toggling every other cycle, L=8 -> `out_data`=0x41000000 (8.0), within the latency bound.
- `out_ready` held low 5 cycles -> `out_valid`=1 with `out_data` stable and `in_ready`=0. The next reduction 2.0+2.0 -> 0x40800000.
- `rst` pulsed during DRAIN -> all outputs at reset values in the same cycle. A following reduction 3.0+1.0 -> 0x40800000 with no stale contribution.
- `REDUCE_F32_NAN_FLAG_EN` defined, stream 1.0, 0x7FC00000, last 2.0 -> `nan_seen`=1 with `out_valid`; the next clean reduction gives `nan_seen`=0.
